// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 keyboard receiver and HID keycode decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Set-2 prefix bytes: extended key and key release
    localparam logic [7:0] SCAN_EXT = 8'hE0;
    localparam logic [7:0] SCAN_BRK = 8'hF0;

    // HID codes produced for the keys the game logic cares about
    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;

    typedef struct packed {
        logic       valid;
        logic [7:0] hid;
    } hid_map_t;

    // Translate {extended flag, scan byte} into a HID code; valid=0 for keys we ignore
    function automatic hid_map_t scanToHid(input logic ext, input logic [7:0] scan);
        hid_map_t m;
        m.valid = 1'b1;
        m.hid   = HID_NONE;
        case ({ext, scan})
            9'h01C:  m.hid = HID_A;
            9'h023:  m.hid = HID_D;
            9'h01B:  m.hid = HID_S;
            9'h01D:  m.hid = HID_W;
            9'h029:  m.hid = HID_SPACE;
            9'h05A:  m.hid = HID_ENTER;
            9'h175:  m.hid = HID_UP;
            9'h172:  m.hid = HID_DOWN;
            9'h16B:  m.hid = HID_LEFT;
            9'h174:  m.hid = HID_RIGHT;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial frame receiver: pin synchronizers, clock glitch filter, frame FSM and stall timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam int          CNT_W       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [15:0] TIMEOUT_LIM = (TIMEOUT > 65535) ? 16'hFFFF : 16'(TIMEOUT);

    logic [1:0]       r_clkSync;
    logic [1:0]       r_dataSync;
    logic [CNT_W-1:0] r_filtCnt;
    logic             r_filtClk;
    logic             r_fall;
    rx_state_t        r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitCnt;
    logic             r_parity;
    logic [15:0]      r_timer;
    logic [7:0]       r_byte;
    logic             r_byteValid;
    logic             r_err;
    logic             w_data;

    assign w_data       = r_dataSync[1];
    assign o_byte       = r_byte;
    assign o_byte_valid = r_byteValid;
    assign o_err        = r_err;

    // Two-flop synchronizers for both pins, preset to the idle-high bus level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], i_ps2_clk};
            r_dataSync <= {r_dataSync[0], i_ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it; falls are strobed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_filtCnt <= '0;
            r_filtClk <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clkSync[1] != r_filtClk) begin
                if (r_filtCnt == FILT_LAST) begin
                    r_filtClk <= r_clkSync[1];
                    r_filtCnt <= '0;
                    r_fall    <= r_filtClk;
                end else begin
                    r_filtCnt <= r_filtCnt + 1'b1;
                end
            end else begin
                r_filtCnt <= '0;
            end
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; abandons a stalled frame on timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RX_IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_parity    <= 1'b0;
            r_timer     <= '0;
            r_byte      <= '0;
            r_byteValid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_err       <= 1'b0;
            if (r_fall) begin
                r_timer <= '0;
                case (r_state)
                    RX_IDLE: begin
                        if (!w_data) begin
                            r_state  <= RX_DATA;
                            r_bitCnt <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        r_state <= RX_IDLE;
                        if (w_data && (^{r_shift, r_parity})) begin
                            r_byte      <= r_shift;
                            r_byteValid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end else if (r_state != RX_IDLE) begin
                if (r_timer >= TIMEOUT_LIM) begin
                    r_state <= RX_IDLE;
                    r_err   <= 1'b1;
                    r_timer <= '0;
                end else if (r_timer != 16'hFFFF) begin
                    r_timer <= r_timer + 16'd1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 Set-2 keyboard to HID keycode: handles E0/F0 prefixes and holds the last pressed key.
module ps2_keycode
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byteValid;
    logic       w_err;
    hid_map_t   w_map;
    logic       r_ext;
    logic       r_brk;
    logic [7:0] r_keycode;
    logic       r_keyEvent;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byteValid),
        .o_err        (w_err)
    );

    assign w_map     = scanToHid(r_ext, w_byte);
    assign keycode   = r_keycode;
    assign key_event = r_keyEvent;
    assign frame_err = w_err;

    // Prefix tracking and held-key update; key_event fires only when keycode actually changes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_keycode  <= HID_NONE;
            r_keyEvent <= 1'b0;
        end else begin
            r_keyEvent <= 1'b0;
            if (w_byteValid) begin
                if (w_byte == SCAN_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SCAN_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (w_map.valid) begin
                        if (r_brk) begin
                            if (w_map.hid == r_keycode) begin
                                r_keycode  <= HID_NONE;
                                r_keyEvent <= 1'b1;
                            end
                        end else if (w_map.hid != r_keycode) begin
                            r_keycode  <= w_map.hid;
                            r_keyEvent <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

Receives PS/2 Set-2 scan codes from the keyboard port and produces the 8-bit USB-HID-style `keycode` that the ball and game logic consume (04=A, 07=D, 16=S, 1A=W, etc.). It sits between the board PS/2 pins and every keycode consumer. It handles the serial frame, the E0/F0 prefixes and key release, and holds the code of the most recently pressed key until that key is released.

## Interface
- FILTER_LEN, 8: consecutive identical synchronized samples required to accept a ps2_clk level change.
- TIMEOUT, 50000: Clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  reset; one clock, asynchronous, active-high.
- ps2_clk  input  1  raw keyboard clock, asynchronous to Clk.
- ps2_data  input  1  raw keyboard data, asynchronous to Clk.
- keycode  output  8  HID code of the held key; 8'h00 when none.
- key_event  output  1  one-cycle pulse whenever keycode changes value.
- frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Both pins pass through 2-FF synchronizers. ps2_clk is then filtered:
  - The filtered level changes only after FILTER_LEN equal consecutive samples.
  - A falling edge of the filtered clock samples ps2_data.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- Receiver FSM: IDLE -> DATA (8 edges) -> PARITY -> STOP -> IDLE.
  - IDLE ignores edges where data=1; that is a start error, so it pulses frame_err.
  - Bad parity or stop=0 discards the byte and pulses frame_err.
  - The timeout counter resets on each edge and runs only outside IDLE. Expiry returns the FSM to IDLE and pulses frame_err.
- Decoder flags `ext` (E0 seen) and `brk` (F0 seen) are set by their prefix bytes. Both clear after the next non-prefix byte.
- Mapping is {ext, scan} -> HID:
  - 0_1C->04, 0_23->07, 0_1B->16, 0_1D->1A.
  - 0_29->2C, 0_5A->28.
  - 1_75->52, 1_72->51, 1_6B->50, 1_74->4F.
  - Anything else is unmapped.
- Make of a mapped key: keycode <= HID. This applies even if another key is already held; last press wins.
- Break of a mapped key whose HID equals the current keycode: keycode <= 00.
- Break of a different key, or make/break of an unmapped key: no change, no key_event.
- Typematic repeat (same make while held): keycode unchanged, no key_event.
- Reset values:
  - keycode=00, key_event=0, frame_err=0.
  - FSM=IDLE, ext=brk=0, filters preset to 1 (idle bus level).

## Timing
- Sampling latency: 2 + FILTER_LEN Clk cycles from a raw ps2_clk falling edge to the sampling cycle. Glitches shorter than FILTER_LEN cycles are rejected.
- keycode and key_event update exactly 2 Clk after the stop-bit sampling cycle: byte register, then decode register.
- frame_err asserts 1 Clk after the offending sample or timeout expiry.
- A new frame may start on the edge immediately after STOP. There is no dead time.
- Reset mid-frame discards the partial byte and any pending prefix flags. The next complete frame decodes normally.
- The TIMEOUT counter is 16 bits and saturates; no wrap.

## Structure
- ps2_pkg holds:
  - the rx state enum;
  - the Set-2 prefix constants E0 and F0;
  - the HID keycode constants for every mapped key;
  - the scan-to-HID mapping function.
- Sub-module ps2_rx contains the synchronizers, filter, frame FSM and timeout. It outputs `byte[7:0]`, `byte_valid` and `err`.
- ps2_keycode instantiates ps2_rx and implements the prefix/decode and hold logic.

## Test plan
- Send frame 1C -> keycode 04 two cycles after the stop sample, key_event one pulse. Then send F0, 1C -> keycode 00, key_event pulse.
- Send E0, 75 -> keycode 52. Send E0, F0, 75 -> keycode 00. Send 75 alone (keypad 8, unmapped) -> no change.
- Send 1D (W), then 23 (D), then F0 1D -> keycode 1A, then 07, then stays 07 with no key_event. Send F0 23 -> 00.
- Send frame 1C with even parity -> frame_err pulse, keycode stays 00. Next valid 1B -> 16.
- Send 5 bits then stall for TIMEOUT+10 cycles -> frame_err pulse, FSM IDLE. A full 29 frame afterwards -> keycode 2C.
- Inject 3-cycle glitches on ps2_clk during a 1C frame -> frame still decodes to 04.
- Assert Reset mid-frame after an E0 prefix, then send 75 -> keycode stays 00, since ext is cleared and plain 75 is unmapped.
